// File: rtl/disp_pkg.sv
// Shared types and defaults for the disparity median filter stage.
package disp_pkg;

  localparam int DISP_WIDTH    = 16;
  localparam int DISP_LANES    = 8;
  localparam int DISP_ROW_SIZE = 1280;
  localparam int BEATS_PER_ROW = DISP_ROW_SIZE / DISP_LANES;

  localparam logic [DISP_WIDTH-1:0] INVALID_VAL = 16'h8000;

  typedef logic signed [DISP_WIDTH-1:0] disp_t;
  typedef disp_t beat_t [DISP_LANES];

  typedef enum logic [1:0] {IDLE, HOLD, LAST} state_t;

endpackage

// File: rtl/disp_median3.sv
// Invalid-aware 3-tap median for one pixel: invalid or missing neighbours
// are replaced by the centre pixel before taking the median.
module disp_median3 #(
  parameter int DATA_WIDTH = disp_pkg::DISP_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INVALID_VAL = disp_pkg::INVALID_VAL
) (
  input  logic signed [DATA_WIDTH-1:0] l,
  input  logic signed [DATA_WIDTH-1:0] p,
  input  logic signed [DATA_WIDTH-1:0] r,
  input  logic                         l_vld,
  input  logic                         r_vld,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic signed [DATA_WIDTH-1:0] lq;
  logic signed [DATA_WIDTH-1:0] rq;
  logic signed [DATA_WIDTH-1:0] lo;
  logic signed [DATA_WIDTH-1:0] hi;
  logic signed [DATA_WIDTH-1:0] hi_r;

  // median(a,b,c) = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lq   = (l_vld && (l != INVALID_VAL)) ? l : p;
    rq   = (r_vld && (r != INVALID_VAL)) ? r : p;
    lo   = (lq < p) ? lq : p;
    hi   = (lq < p) ? p : lq;
    hi_r = (hi < rq) ? hi : rq;
    y    = (lo < hi_r) ? hi_r : lo;
    if (p == INVALID_VAL) y = p;
  end

endmodule

// File: rtl/disparity_median_filter.sv
// AXI-Stream horizontal 3-tap median filter for disparity rows, holding one
// beat so the rightmost lane can see the next beat's leftmost pixel.
module disparity_median_filter #(
  parameter int ROW_SIZE   = disp_pkg::DISP_ROW_SIZE,
  parameter int BEAT_SIZE  = disp_pkg::DISP_LANES,
  parameter int DATA_WIDTH = disp_pkg::DISP_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INVALID_VAL = disp_pkg::INVALID_VAL
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic                            row_len_err
);
  import disp_pkg::*;

  localparam int ROW_BEATS = ROW_SIZE / BEAT_SIZE;
  localparam int CNT_W     = $clog2(ROW_BEATS + 1) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_BEATS - 1);

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] cur   [BEAT_SIZE];
  logic signed [DATA_WIDTH-1:0] in_px [BEAT_SIZE];
  logic signed [DATA_WIDTH-1:0] left_px;
  logic                         row_start;
  logic [CNT_W-1:0]             beat_cnt;
  logic [BEAT_SIZE*DATA_WIDTH-1:0] filt_flat;
  logic                         out_free;
  logic                         accept;

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign accept   = s_axis_tvalid && s_axis_tready;

  always_comb begin
    s_axis_tready = 1'b0;
    case (state)
      IDLE:    s_axis_tready = 1'b1;
      HOLD:    s_axis_tready = out_free;
      default: s_axis_tready = 1'b0;
    endcase
  end

  for (genvar k = 0; k < BEAT_SIZE; k++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] l_px;
    logic signed [DATA_WIDTH-1:0] r_px;
    logic signed [DATA_WIDTH-1:0] y_px;
    logic                         l_vld;
    logic                         r_vld;

    assign in_px[k] = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];

    if (k == 0) begin : g_first
      assign l_px  = left_px;
      assign l_vld = !row_start;
    end else begin : g_inner_l
      assign l_px  = cur[k-1];
      assign l_vld = 1'b1;
    end

    // The incoming beat only exists as a right neighbour while a row continues
    if (k == BEAT_SIZE-1) begin : g_last
      assign r_px  = in_px[0];
      assign r_vld = (state == HOLD);
    end else begin : g_inner_r
      assign r_px  = cur[k+1];
      assign r_vld = 1'b1;
    end

    disp_median3 #(
      .DATA_WIDTH  (DATA_WIDTH),
      .INVALID_VAL (INVALID_VAL)
    ) u_med (
      .l     (l_px),
      .p     (cur[k]),
      .r     (r_px),
      .l_vld (l_vld),
      .r_vld (r_vld),
      .y     (y_px)
    );

    assign filt_flat[k*DATA_WIDTH +: DATA_WIDTH] = y_px;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      row_len_err   <= 1'b0;
      beat_cnt      <= '0;
      row_start     <= 1'b1;
      left_px       <= '0;
      for (int k = 0; k < BEAT_SIZE; k++) cur[k] <= '0;
    end else begin
      row_len_err <= 1'b0;
      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            cur   <= in_px;
            state <= s_axis_tlast ? LAST : HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            m_axis_tdata  <= filt_flat;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            left_px       <= cur[BEAT_SIZE-1];
            row_start     <= 1'b0;
            cur           <= in_px;
            state         <= s_axis_tlast ? LAST : HOLD;
          end
        end
        LAST: begin
          if (out_free) begin
            m_axis_tdata  <= filt_flat;
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
            row_start     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Length check only flags; rows stay delimited by the input tlast
      if (accept) begin
        if (s_axis_tlast) begin
          beat_cnt    <= '0;
          row_len_err <= (beat_cnt != LAST_IDX);
        end else begin
          beat_cnt    <= beat_cnt + 1'b1;
          row_len_err <= (beat_cnt == LAST_IDX);
        end
      end
    end
  end

endmodule

// File: tb/tb_disparity_median_filter.sv
// Directed bench for disparity_median_filter with 32-pixel rows of 8 lanes.
module tb_disparity_median_filter;

  localparam int DW  = 16;
  localparam int BS  = 8;
  localparam int RS  = 32;
  localparam int INV = 32768;

  logic           aclk = 1'b0;
  logic           areset;
  logic [BS*DW-1:0] s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic [BS*DW-1:0] m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic           row_len_err;

  always #5 aclk = ~aclk;

  disparity_median_filter #(
    .ROW_SIZE    (RS),
    .BEAT_SIZE   (BS),
    .DATA_WIDTH  (DW),
    .INVALID_VAL (16'h8000)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .row_len_err   (row_len_err)
  );

  int checks = 0;
  int errors = 0;

  logic [BS*DW-1:0] tx_data [4];
  int               tx_n, tx_idx, tx_upto, cyc_cnt;
  logic [3:0]       rdy_pat;
  logic [BS*DW-1:0] rx_data [$];
  logic             rx_last [$];
  int               err_cnt, accepted, emitted;
  int               stall_viol, tready_viol, stall_cnt;
  logic             prev_stall;
  logic [BS*DW-1:0] prev_data;
  logic             prev_last;

  function automatic logic [BS*DW-1:0] pk(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7);
    return {16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [BS*DW-1:0] ramp(input int b);
    return pk(b*8, b*8+1, b*8+2, b*8+3, b*8+4, b*8+5, b*8+6, b*8+7);
  endfunction

  // One cycle: drive at the falling edge, then observe what the next rising edge transfers
  task automatic step();
    int held;
    @(negedge aclk);
    s_axis_tvalid = (tx_idx < tx_upto);
    s_axis_tdata  = (tx_idx < 4) ? tx_data[tx_idx] : '0;
    s_axis_tlast  = s_axis_tvalid && (tx_idx == tx_n - 1);
    m_axis_tready = rdy_pat[cyc_cnt % 4];
    cyc_cnt++;
    #1;
    held = accepted - emitted - (m_axis_tvalid ? 1 : 0);
    if (held > 0 && m_axis_tvalid && !m_axis_tready && s_axis_tready) tready_viol++;
    if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
      stall_viol++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    if (prev_stall) stall_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      rx_data.push_back(m_axis_tdata);
      rx_last.push_back(m_axis_tlast);
      emitted++;
    end
    if (s_axis_tvalid && s_axis_tready) begin
      tx_idx++;
      accepted++;
    end
    if (row_len_err) err_cnt++;
  endtask

  task automatic drive(input int upto, input int want, input logic [3:0] pat);
    int n;
    n       = 0;
    tx_upto = upto;
    rdy_pat = pat;
    cyc_cnt = 0;
    while ((tx_idx < upto || rx_data.size() < want) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL drive_timeout sent %0d of %0d, got %0d of %0d beats", tx_idx, upto, rx_data.size(), want);
    end
    repeat (3) step();
  endtask

  task automatic start_row(input int n);
    tx_idx  = 0;
    tx_n    = n;
    tx_upto = 0;
    err_cnt = 0;
    rx_data.delete();
    rx_last.delete();
  endtask

  task automatic test_reset();
    areset = 1'b1;
    tx_idx = 0; tx_upto = 0; tx_n = 4; rdy_pat = 4'hF;
    accepted = 0; emitted = 0; prev_stall = 1'b0;
    step();
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata got %h want 0", m_axis_tdata); end
    checks++; if (row_len_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", row_len_err); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready got %b want 1", s_axis_tready); end
    areset = 1'b0;
    step();
  endtask

  task automatic test_spike();
    logic [BS*DW-1:0] want;
    start_row(4);
    tx_data[0] = pk(10, 10, 10, 10, 10, 10, 10, 10);
    tx_data[1] = pk(10, 10, 10, 200, 10, 10, 10, 10);
    tx_data[2] = tx_data[0];
    tx_data[3] = tx_data[0];
    want = pk(10, 10, 10, 10, 10, 10, 10, 10);
    drive(4, 4, 4'hF);
    checks++; if (rx_data.size() != 4) begin errors++; $display("[TB] FAIL spike_count got %0d want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      checks++; if (rx_data[i] !== want) begin errors++; $display("[TB] FAIL spike_data beat%0d got %h want %h", i, rx_data[i], want); end
      checks++; if (rx_last[i] !== (i == 3)) begin errors++; $display("[TB] FAIL spike_last beat%0d got %b want %b", i, rx_last[i], i == 3); end
    end
    checks++; if (err_cnt != 0) begin errors++; $display("[TB] FAIL spike_len_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_boundary_spike();
    logic [BS*DW-1:0] want;
    start_row(4);
    tx_data[0] = pk(20, 20, 20, 20, 20, 20, 20, -50);
    tx_data[1] = pk(20, 20, 20, 20, 20, 20, 20, 20);
    tx_data[2] = tx_data[1];
    tx_data[3] = tx_data[1];
    want = tx_data[1];
    drive(1, 0, 4'hF);
    checks++; if (rx_data.size() != 0 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL boundary_early got %0d beats valid %b want 0 beats valid 0", rx_data.size(), m_axis_tvalid);
    end
    drive(4, 4, 4'hF);
    checks++; if (rx_data.size() != 4) begin errors++; $display("[TB] FAIL boundary_count got %0d want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      checks++; if (rx_data[i] !== want) begin errors++; $display("[TB] FAIL boundary_data beat%0d got %h want %h", i, rx_data[i], want); end
    end
  endtask

  task automatic test_invalid();
    logic [BS*DW-1:0] want [4];
    start_row(4);
    tx_data[0] = pk(4, 4, 2, 5, INV, 7, 3, 3);
    tx_data[1] = pk(3, 3, 3, 3, 3, 3, 3, 3);
    tx_data[2] = tx_data[1];
    tx_data[3] = pk(3, 3, 3, 3, 3, 3, 3, 50);
    want[0] = pk(4, 4, 4, 5, INV, 7, 3, 3);
    want[1] = tx_data[1];
    want[2] = tx_data[1];
    want[3] = pk(3, 3, 3, 3, 3, 3, 3, 50);
    drive(4, 4, 4'hF);
    checks++; if (rx_data.size() != 4) begin errors++; $display("[TB] FAIL invalid_count got %0d want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      checks++; if (rx_data[i] !== want[i]) begin errors++; $display("[TB] FAIL invalid_data beat%0d got %h want %h", i, rx_data[i], want[i]); end
    end
  endtask

  task automatic test_backpressure();
    start_row(4);
    for (int b = 0; b < 4; b++) tx_data[b] = ramp(b);
    stall_viol = 0; tready_viol = 0; stall_cnt = 0;
    drive(4, 4, 4'b1001);
    checks++; if (rx_data.size() != 4) begin errors++; $display("[TB] FAIL bp_count got %0d want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      checks++; if (rx_data[i] !== ramp(i)) begin errors++; $display("[TB] FAIL bp_data beat%0d got %h want %h", i, rx_data[i], ramp(i)); end
      checks++; if (rx_last[i] !== (i == 3)) begin errors++; $display("[TB] FAIL bp_last beat%0d got %b want %b", i, rx_last[i], i == 3); end
    end
    checks++; if (stall_viol != 0) begin errors++; $display("[TB] FAIL bp_stable got %0d changes want 0", stall_viol); end
    checks++; if (tready_viol != 0) begin errors++; $display("[TB] FAIL bp_tready got %0d violations want 0", tready_viol); end
    checks++; if (stall_cnt == 0) begin errors++; $display("[TB] FAIL bp_stalls got 0 stall cycles want >0"); end
  endtask

  task automatic test_row_length();
    logic [BS*DW-1:0] want0;
    start_row(3);
    for (int b = 0; b < 3; b++) tx_data[b] = ramp(b);
    drive(3, 3, 4'hF);
    checks++; if (err_cnt != 1) begin errors++; $display("[TB] FAIL short_row_err got %0d want 1", err_cnt); end
    checks++; if (rx_data.size() != 3) begin errors++; $display("[TB] FAIL short_row_count got %0d want 3", rx_data.size()); end
    for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
      checks++; if (rx_data[i] !== ramp(i)) begin errors++; $display("[TB] FAIL short_row_data beat%0d got %h want %h", i, rx_data[i], ramp(i)); end
      checks++; if (rx_last[i] !== (i == 2)) begin errors++; $display("[TB] FAIL short_row_last beat%0d got %b want %b", i, rx_last[i], i == 2); end
    end
    start_row(4);
    tx_data[0] = pk(100, 0, 0, 0, 0, 0, 0, 0);
    for (int b = 1; b < 4; b++) tx_data[b] = '0;
    want0 = tx_data[0];
    drive(4, 4, 4'hF);
    checks++; if (err_cnt != 0) begin errors++; $display("[TB] FAIL full_row_err got %0d want 0", err_cnt); end
    checks++; if (rx_data.size() != 4) begin errors++; $display("[TB] FAIL full_row_count got %0d want 4", rx_data.size()); end
    if (rx_data.size() > 0) begin
      checks++; if (rx_data[0] !== want0) begin errors++; $display("[TB] FAIL full_row_edge got %h want %h", rx_data[0], want0); end
    end
  endtask

  task automatic test_reset_mid_row();
    logic [BS*DW-1:0] want0;
    start_row(4);
    for (int b = 0; b < 4; b++) tx_data[b] = ramp(b + 4);
    drive(2, 0, 4'b0000);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL midrow_pending got valid %b want 1", m_axis_tvalid); end
    areset = 1'b1;
    step();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrow_reset_valid got %b want 0", m_axis_tvalid); end
    areset = 1'b0;
    accepted = 0; emitted = 0; prev_stall = 1'b0;
    start_row(4);
    tx_data[0] = pk(100, 0, 0, 0, 0, 0, 0, 0);
    for (int b = 1; b < 4; b++) tx_data[b] = '0;
    want0 = tx_data[0];
    drive(4, 4, 4'hF);
    checks++; if (rx_data.size() != 4) begin errors++; $display("[TB] FAIL midrow_count got %0d want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      checks++; if (rx_data[i] !== ((i == 0) ? want0 : '0)) begin
        errors++; $display("[TB] FAIL midrow_data beat%0d got %h want %h", i, rx_data[i], (i == 0) ? want0 : '0);
      end
      checks++; if (rx_last[i] !== (i == 3)) begin errors++; $display("[TB] FAIL midrow_last beat%0d got %b want %b", i, rx_last[i], i == 3); end
    end
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    prev_stall    = 1'b0;
    prev_data     = '0;
    prev_last     = 1'b0;
    err_cnt = 0; stall_viol = 0; tready_viol = 0; stall_cnt = 0;
    test_reset();
    test_spike();
    test_boundary_spike();
    test_invalid();
    test_backpressure();
    test_row_length();
    test_reset_mid_row();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
